uart_tx_ctrl: RTL and testbench

//  Sequencer for the UART transmit path. Accepts bytes from the CPU side over a

---
 rtl/uart_tx_ctrl.sv | 110 +++++++++++
 tb/tb_uart_tx_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit sequencer: byte buffer, baud pacing, shift-register control
//
// Purpose: accepts one byte at a time over a valid/ready handshake into a
// single-entry holding buffer, then frames it as {stop, data, start} for an
// external 10-bit shift register and paces one shift per bit period.
// Consecutive frames run with no idle gap when the buffer refills in time.
//
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   tx_valid    byte offered on tx_data
//   tx_data     byte to send, LSB first on the line
//   tx_ready    holding buffer empty
//   tx_busy     frame on the line or byte waiting in the buffer
//   tx_done     one-cycle pulse in the last cycle of each stop bit
//   sr_frame    parallel frame for the shift register
//   sr_load     1 = parallel load, 0 = shift in ones
//   sr_en       shift-register clock enable
//   sr_out      shift-register serial output
//   tx          UART line, forced high outside a frame
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [9:0] sr_frame,
  output logic       sr_load,
  output logic       sr_en,
  input  logic       sr_out,
  output logic       tx
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state;
  logic [7:0]    hold_data;
  logic          hold_valid;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;

  logic accept;
  logic bit_end;
  logic frame_end;
  logic pop;

  assign accept    = tx_valid && !hold_valid;
  assign bit_end   = (state == SEND) && (baud_cnt == BAUD_LAST);
  assign frame_end = bit_end && (bit_cnt == 4'd9);
  // A new frame is launched either from idle or straight off the end of the
  // previous stop bit, which is what gives back-to-back frames zero gap.
  assign pop       = hold_valid && ((state == IDLE) || frame_end);

  assign tx_ready = !hold_valid;
  assign tx_busy  = (state == SEND) || hold_valid;
  assign tx_done  = frame_end;
  assign sr_frame = {1'b1, hold_data, 1'b0};
  assign sr_load  = pop;
  assign sr_en    = pop || (bit_end && (bit_cnt != 4'd9));
  assign tx       = (state == SEND) ? sr_out : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_data  <= 8'h00;
      hold_valid <= 1'b0;
      baud_cnt   <= '0;
      bit_cnt    <= 4'd0;
    end else begin
      // accept needs an empty buffer and pop needs a full one, so they never collide
      if (accept) begin
        hold_data  <= tx_data;
        hold_valid <= 1'b1;
      end else if (pop) begin
        hold_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            state    <= SEND;
            baud_cnt <= '0;
            bit_cnt  <= 4'd0;
          end
        end
        SEND: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd9) begin
              bit_cnt <= 4'd0;
              if (!hold_valid) state <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl with shift-register and UART-RX models
module tb_uart_tx_ctrl;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_busy, tx_done, sr_load, sr_en, tx;
  logic [9:0] sr_frame;
  logic       sr_out;
  logic [9:0] sreg;

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done),
    .sr_frame(sr_frame), .sr_load(sr_load), .sr_en(sr_en),
    .sr_out(sr_out), .tx(tx)
  );

  always #5 clk = ~clk;

  // external 10-bit shift register, shifts toward bit 0 filling with ones
  always @(posedge clk or posedge rst) begin
    if (rst) sreg <= 10'h3FF;
    else if (sr_en) sreg <= sr_load ? sr_frame : {1'b1, sreg[9:1]};
  end
  assign sr_out = sreg[0];

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int frames = 0;
  int n_acc = 0;
  logic [7:0] exp_q[$];
  int done_t[$];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // UART-RX model: samples every cycle, checks each bit holds for CPB cycles
  int         rx_idx = 0;
  bit         rx_active = 0;
  bit         rx_width_ok;
  logic [9:0] rx_bits;
  always @(negedge clk) begin
    if (rst) begin
      rx_active = 0;
      exp_q.delete();
    end else begin
      if (!rx_active && tx == 1'b0) begin
        rx_active = 1;
        rx_idx = 0;
        rx_width_ok = 1;
      end
      if (rx_active) begin
        if (rx_idx % CPB == 0) rx_bits[rx_idx / CPB] = tx;
        else if (tx !== rx_bits[rx_idx / CPB]) rx_width_ok = 0;
        if (rx_idx == 10 * CPB - 1) begin
          check("rx_done_at_stop_end", tx_done, 1'b1);
          check("rx_bit_width", rx_width_ok, 1'b1);
          check("rx_stop_bit", rx_bits[9], 1'b1);
          if (exp_q.size() == 0) check("rx_unexpected_frame", 1, 0);
          else check("rx_data", rx_bits[8:1], exp_q.pop_front());
          frames++;
          done_t.push_back(cycle);
          rx_active = 0;
        end else if (tx_done) begin
          check("rx_spurious_done", tx_done, 1'b0);
        end
        rx_idx++;
      end else if (tx_done) begin
        check("rx_spurious_done_idle", tx_done, 1'b0);
      end
    end
  end

  // called at a negedge; returns at the negedge right after the accepting edge
  task automatic send(input logic [7:0] d, input bit keep);
    int n = 0;
    tx_valid = 1'b1;
    tx_data = d;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 1, 0);
    else begin
      exp_q.push_back(d);
      n_acc++;
    end
    @(negedge clk);
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((tx_busy || !tx) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;
  vec_t vecs[5];

  initial begin
    bit ok;
    int f0, a0;
    vecs[0] = '{8'hA5, 10'h34A};
    vecs[1] = '{8'h00, 10'h200};
    vecs[2] = '{8'hFF, 10'h3FE};
    vecs[3] = '{8'h3C, 10'h278};
    vecs[4] = '{8'h81, 10'h302};

    // reset idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_tx", tx, 1'b1);
    check("reset_ready", tx_ready, 1'b1);
    check("reset_busy", tx_busy, 1'b0);
    check("reset_done", tx_done, 1'b0);
    ok = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sr_en || sr_load || !tx || !tx_ready || tx_busy) ok = 0;
    end
    check("idle_50_cycles", ok, 1'b1);

    // table-driven single frames: latency, exact bit pattern, end-of-frame state
    for (int v = 0; v < 5; v++) begin
      send(vecs[v].data, 0);
      check($sformatf("v%0d_load", v), {sr_load, sr_en}, 2'b11);
      check($sformatf("v%0d_frame", v), sr_frame, vecs[v].frame);
      for (int b = 0; b < 10; b++) begin
        ok = 1;
        for (int k = 0; k < CPB; k++) begin
          @(negedge clk);
          if (tx !== vecs[v].frame[b]) ok = 0;
          if (b == 9 && k == CPB - 1) check($sformatf("v%0d_done", v), tx_done, 1'b1);
        end
        check($sformatf("v%0d_bit%0d", v, b), ok, 1'b1);
      end
      @(negedge clk);
      check($sformatf("v%0d_idle", v), {tx, tx_busy, tx_ready}, 3'b101);
    end

    // back-to-back: second byte accepted mid-frame, held until the stop bit ends
    f0 = frames;
    send(8'h00, 0);
    send(8'hFF, 0);
    check("b2b_ready_low", tx_ready, 1'b0);
    check("b2b_busy", tx_busy, 1'b1);
    wait_idle();
    check("b2b_frames", frames - f0, 2);
    if (done_t.size() >= 2)
      check("b2b_done_gap", done_t[done_t.size()-1] - done_t[done_t.size()-2], 10 * CPB);

    // backpressure: valid held across three bytes
    f0 = frames;
    a0 = n_acc;
    send(8'h11, 1);
    send(8'h22, 1);
    send(8'h33, 0);
    wait_idle();
    check("bp_accepts", n_acc - a0, 3);
    check("bp_frames", frames - f0, 3);

    // reset mid-frame with a byte buffered
    f0 = frames;
    send(8'h3C, 0);
    send(8'h81, 0);
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_ready", tx_ready, 1'b1);
    check("mid_rst_busy", tx_busy, 1'b0);
    check("mid_rst_sr_en", sr_en, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("mid_rst_no_frame", frames - f0, 0);
    send(8'h5A, 0);
    wait_idle();
    check("post_rst_frame", frames - f0, 1);

    // random bytes with random gaps
    f0 = frames;
    for (int i = 0; i < 200; i++) begin
      send(8'($urandom_range(0, 255)), 0);
      repeat ($urandom_range(0, 45)) @(negedge clk);
    end
    wait_idle();
    check("rand_frames", frames - f0, 200);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
